clock_time_counter: RTL and testbench

- 24-hour HH:MM time-of-day counter for the alarm clock, with four 4-bit BCD digits (ms_hr, ls_hr, ms_min, ls_min).
- Advances one minute per one_minute strobe.
- Can be preset in parallel from the keypad/FSM path via load_new_c.
- Sits between the one-minute timebase generator and the display/alarm-compare logic.

---
 rtl/alarm_clock_pkg.sv | 25 ++
 rtl/bcd_digit_cnt.sv | 29 ++
 rtl/clock_time_counter.sv | 84 ++++++++
 tb/tb_clock_time_counter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alarm_clock_pkg.sv
// Shared digit limits and BCD digit type for the alarm clock time-of-day path.
// Also holds the load validity check used when COUNTER_LOAD_VALIDATE_EN is defined.
package alarm_clock_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t LS_MIN_MAX = 4'd9;
  localparam bcd_digit_t MS_MIN_MAX = 4'd5;
  localparam bcd_digit_t LS_HR_MAX  = 4'd9;
  localparam bcd_digit_t HR_WRAP_MS = 4'd2;
  localparam bcd_digit_t HR_WRAP_LS = 4'd3;

  // True when the four digits form a legal 24-hour HH:MM time.
  function automatic logic time_is_valid(input bcd_digit_t ms_hr,
                                         input bcd_digit_t ls_hr,
                                         input bcd_digit_t ms_min,
                                         input bcd_digit_t ls_min);
    logic hour_ok;
    hour_ok = (ms_hr < HR_WRAP_MS) ||
              ((ms_hr == HR_WRAP_MS) && (ls_hr <= HR_WRAP_LS));
    return (ms_hr <= HR_WRAP_MS) && (ls_hr <= LS_HR_MAX) && hour_ok &&
           (ms_min <= MS_MIN_MAX) && (ls_min <= LS_MIN_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit with synchronous reset, parallel load, increment enable and
// programmable maximum; carry is high when an increment wraps the digit.
module bcd_digit_cnt
  import alarm_clock_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  bcd_digit_t load_val,
  input  logic       inc,
  input  bcd_digit_t max_val,
  output bcd_digit_t digit,
  output logic       carry
);

  // >= lets an out-of-range loaded digit wrap on its next increment.
  assign carry = inc && (digit >= max_val);

  always_ff @(posedge clk) begin
    if (reset) begin
      digit <= '0;
    end else if (load) begin
      digit <= load_val;
    end else if (inc) begin
      digit <= carry ? '0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/clock_time_counter.sv
// 24-hour HH:MM BCD time-of-day counter: reset > load > one_minute count > hold.
// Optional macro COUNTER_LOAD_VALIDATE_EN rejects loads that are not a legal time.
module clock_time_counter
  import alarm_clock_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       one_minute,
  input  logic       load_new_c,
  input  logic [3:0] new_current_time_ms_hr,
  input  logic [3:0] new_current_time_ms_min,
  input  logic [3:0] new_current_time_ls_hr,
  input  logic [3:0] new_current_time_ls_min,
  output logic [3:0] current_time_ms_hr,
  output logic [3:0] current_time_ms_min,
  output logic [3:0] current_time_ls_hr,
  output logic [3:0] current_time_ls_min
);

  logic       load_accept;
  logic       count_en;
  logic       ls_min_carry;
  logic       hour_carry;
  bcd_digit_t ms_hr_q;
  bcd_digit_t ls_hr_q;

`ifdef COUNTER_LOAD_VALIDATE_EN
  assign load_accept = load_new_c &&
                       time_is_valid(new_current_time_ms_hr, new_current_time_ls_hr,
                                     new_current_time_ms_min, new_current_time_ls_min);
`else
  assign load_accept = load_new_c;
`endif

  // Any load request, accepted or not, swallows that cycle's minute strobe.
  assign count_en = one_minute && !load_new_c;

  bcd_digit_cnt u_ls_min (
    .clk      (clk),
    .reset    (reset),
    .load     (load_accept),
    .load_val (new_current_time_ls_min),
    .inc      (count_en),
    .max_val  (LS_MIN_MAX),
    .digit    (current_time_ls_min),
    .carry    (ls_min_carry)
  );

  bcd_digit_cnt u_ms_min (
    .clk      (clk),
    .reset    (reset),
    .load     (load_accept),
    .load_val (new_current_time_ms_min),
    .inc      (ls_min_carry),
    .max_val  (MS_MIN_MAX),
    .digit    (current_time_ms_min),
    .carry    (hour_carry)
  );

  // Hour pair kept together so 23 -> 00 can wrap both digits at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_hr_q <= '0;
      ls_hr_q <= '0;
    end else if (load_accept) begin
      ms_hr_q <= new_current_time_ms_hr;
      ls_hr_q <= new_current_time_ls_hr;
    end else if (hour_carry) begin
      if ((ms_hr_q >= HR_WRAP_MS) && (ls_hr_q >= HR_WRAP_LS)) begin
        ms_hr_q <= '0;
        ls_hr_q <= '0;
      end else if (ls_hr_q >= LS_HR_MAX) begin
        ms_hr_q <= ms_hr_q + 4'd1;
        ls_hr_q <= '0;
      end else begin
        ls_hr_q <= ls_hr_q + 4'd1;
      end
    end
  end

  assign current_time_ms_hr = ms_hr_q;
  assign current_time_ls_hr = ls_hr_q;

endmodule

// File: tb/tb_clock_time_counter.sv
// Directed bench for clock_time_counter; time is compared packed as {ms_hr, ls_hr, ms_min, ls_min}.
// Expectations follow COUNTER_LOAD_VALIDATE_EN when the bench is built with it.
module tb_clock_time_counter;

  logic       clk;
  logic       reset;
  logic       one_minute;
  logic       load_new_c;
  logic [3:0] new_current_time_ms_hr;
  logic [3:0] new_current_time_ms_min;
  logic [3:0] new_current_time_ls_hr;
  logic [3:0] new_current_time_ls_min;
  logic [3:0] current_time_ms_hr;
  logic [3:0] current_time_ms_min;
  logic [3:0] current_time_ls_hr;
  logic [3:0] current_time_ls_min;

  logic [15:0] exp_q[$];
  int checks;
  int failures;

  clock_time_counter dut (
    .clk                     (clk),
    .reset                   (reset),
    .one_minute              (one_minute),
    .load_new_c              (load_new_c),
    .new_current_time_ms_hr  (new_current_time_ms_hr),
    .new_current_time_ms_min (new_current_time_ms_min),
    .new_current_time_ls_hr  (new_current_time_ls_hr),
    .new_current_time_ls_min (new_current_time_ls_min),
    .current_time_ms_hr      (current_time_ms_hr),
    .current_time_ms_min     (current_time_ms_min),
    .current_time_ls_hr      (current_time_ls_hr),
    .current_time_ls_min     (current_time_ls_min)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] cur_time();
    return {current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min};
  endfunction

  // Reference: minutes-of-day as an integer, converted to BCD digits.
  function automatic logic [15:0] model_time(input int m);
    int h;
    int mm;
    logic [3:0] d3, d2, d1, d0;
    h  = m / 60;
    mm = m % 60;
    d3 = 4'(h / 10);
    d2 = 4'(h % 10);
    d1 = 4'(mm / 10);
    d0 = 4'(mm % 10);
    return {d3, d2, d1, d0};
  endfunction

  task automatic check(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Scoreboard
  task automatic sb_push(input logic [15:0] exp_val);
    exp_q.push_back(exp_val);
  endtask

  task automatic sb_check(input string tag);
    logic [15:0] exp_val;
    if (exp_q.size() == 0) begin
      check({tag, "_no_expectation"}, cur_time(), 16'hxxxx);
    end else begin
      exp_val = exp_q.pop_front();
      check(tag, cur_time(), exp_val);
    end
  endtask

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_val(input logic [15:0] v);
    new_current_time_ms_hr  = v[15:12];
    new_current_time_ls_hr  = v[11:8];
    new_current_time_ms_min = v[7:4];
    new_current_time_ls_min = v[3:0];
  endtask

  task automatic do_load(input logic [15:0] v, input string tag);
    set_load_val(v);
    load_new_c = 1'b1;
    tick();
    load_new_c = 1'b0;
    sb_push(v);
    sb_check(tag);
  endtask

  task automatic minute(input logic [15:0] exp_val, input string tag);
    one_minute = 1'b1;
    tick();
    one_minute = 1'b0;
    sb_push(exp_val);
    sb_check(tag);
  endtask

  initial begin
    int m;
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    one_minute = 1'b0;
    load_new_c = 1'b0;
    set_load_val(16'h0000);

    for (int i = 0; i < 5; i++) tick();
    sb_push(16'h0000);
    sb_check("reset_state");
    reset = 1'b0;
    tick();
    tick();
    sb_push(16'h0000);
    sb_check("hold_after_reset");

    // Out-of-range load 21:5F, held for two cycles
    set_load_val(16'h215F);
    load_new_c = 1'b1;
    tick();
    tick();
    load_new_c = 1'b0;
`ifdef COUNTER_LOAD_VALIDATE_EN
    sb_push(16'h0000);
    sb_check("load_21_5f_rejected");
    one_minute = 1'b1;
    tick();
    sb_push(16'h0001);
    sb_check("count_after_reject_1");
    tick();
    one_minute = 1'b0;
    sb_push(16'h0002);
    sb_check("count_after_reject_2");
`else
    sb_push(16'h215F);
    sb_check("load_21_5f");
    one_minute = 1'b1;
    tick();
    sb_push(16'h2200);
    sb_check("recover_21_5f");
    tick();
    one_minute = 1'b0;
    sb_push(16'h2201);
    sb_check("count_22_01");
`endif

    do_load(16'h2359, "load_23_59");
    minute(16'h0000, "wrap_23_59");
    do_load(16'h0959, "load_09_59");
    minute(16'h1000, "carry_09_59");
    do_load(16'h1959, "load_19_59");
    minute(16'h2000, "carry_19_59");

    // Load and minute strobe in the same cycle: the minute is dropped
    set_load_val(16'h1234);
    load_new_c = 1'b1;
    one_minute = 1'b1;
    tick();
    load_new_c = 1'b0;
    one_minute = 1'b0;
    sb_push(16'h1234);
    sb_check("load_beats_count");
    tick();
    sb_push(16'h1234);
    sb_check("hold_12_34");
    minute(16'h1235, "count_12_35");

    // Full day with the strobe held high
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb_push(16'h0000);
    sb_check("reset_before_day");
    m = 0;
    one_minute = 1'b1;
    for (int i = 0; i < 1440; i++) begin
      tick();
      m = (m + 1) % 1440;
      sb_push(model_time(m));
      sb_check("day_step");
    end
    one_minute = 1'b0;
    sb_push(16'h0000);
    sb_check("day_wrap");

    // Reset beats a simultaneous load
    do_load(16'h1234, "load_before_reset");
    set_load_val(16'h0555);
    load_new_c = 1'b1;
    reset      = 1'b1;
    tick();
    load_new_c = 1'b0;
    reset      = 1'b0;
    sb_push(16'h0000);
    sb_check("reset_beats_load");
    tick();
    sb_push(16'h0000);
    sb_check("hold_after_reset_load");

    // Final report
    if (exp_q.size() != 0) check("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
